// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the mul32 arbiter slice.
package mul_arb_pkg;

  localparam int unsigned OP_W        = 32;
  localparam int unsigned PROD_W      = 64;
  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mul_arb_state_e;

endpackage

// File: rtl/mul_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mul_arb_rr_pick
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    index,
  output logic             any
);

  int unsigned    sum;
  logic [IW-1:0]  pos;

  always_comb begin
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    sum   = 0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      pos = IW'(sum);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        index    = pos;
      end
    end
  end

endmodule

// File: rtl/mul32_arbiter.sv
// Round-robin arbiter sharing one mul32 among N_REQ requesters.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul32_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = N_REQ_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*OP_W-1:0]   req_mc_i,
  input  logic [N_REQ*OP_W-1:0]   req_mp_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [PROD_W-1:0]       rsp_p_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic                    mul_start_o,
  output logic [OP_W-1:0]         mul_mc_o,
  output logic [OP_W-1:0]         mul_mp_o,
  input  logic [PROD_W-1:0]       mul_p_i,
  input  logic                    mul_done_i
);

  localparam int unsigned IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("mul32_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  mul_arb_state_e     state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [PROD_W-1:0]  rsp_p_q, rsp_p_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [OP_W-1:0]    mc_q, mc_d;
  logic [OP_W-1:0]    mp_q, mp_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  mul_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    busy_d      = busy_q;
    start_d     = start_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          mc_d    = req_mc_i[pick_idx*OP_W +: OP_W];
          mp_d    = req_mp_i[pick_idx*OP_W +: OP_W];
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b0;
        state_d = WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // The response vector is the held grant, so rsp_valid_o is one-hot by construction.
        if (mul_done_i) begin
          rsp_p_d     = mul_p_i;
          rsp_valid_d = gnt_q;
          state_d     = RESP;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_p_d     = '0;
          rsp_valid_d = gnt_q;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        rsp_valid_d = '0;
        gnt_d       = '0;
        busy_d      = 1'b0;
        rr_ptr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      mc_q        <= '0;
      mp_q        <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_p_o     = rsp_p_q;
  assign busy_o      = busy_q;
  assign mul_start_o = start_q;
  assign mul_mc_o    = mc_q;
  assign mul_mp_o    = mp_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mul32_arbiter.sv
// Self-checking bench for mul32_arbiter with a variable-latency multiplier stub.
module tb_mul32_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_i;
  logic [127:0]  mc_bus, mp_bus;
  logic [3:0]    gnt_o, rsp_valid_o;
  logic [63:0]   rsp_p_o;
  logic          rsp_err_o, busy_o, mul_start_o;
  logic [31:0]   mul_mc_o, mul_mp_o;
  logic [63:0]   mul_p;
  logic          mul_done;

  logic          stub_done, late_done;
  logic [63:0]   stub_p;
  int            stub_cnt;
  bit            stub_hold;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            rr;
  logic [31:0]   mca [4];
  logic [31:0]   mpa [4];
  int            k, n;

  always #5 clk = ~clk;

  mul32_arbiter #(
    .N_REQ          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_i       (req_i),
    .req_mc_i    (mc_bus),
    .req_mp_i    (mp_bus),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_p_o     (rsp_p_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .mul_start_o (mul_start_o),
    .mul_mc_o    (mul_mc_o),
    .mul_mp_o    (mul_mp_o),
    .mul_p_i     (mul_p),
    .mul_done_i  (mul_done)
  );

  // Multiplier stub: clears done on start, raises it after a random latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_p    <= '0;
    end else if (mul_start_o) begin
      stub_done <= 1'b0;
      stub_cnt  <= int'($urandom_range(1, 6));
      stub_p    <= 64'(mul_mc_o) * 64'(mul_mp_o);
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hold) stub_done <= 1'b1;
    end
  end

  assign mul_p    = stub_p;
  assign mul_done = stub_done | late_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int j = (p + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      mc_bus[i*32 +: 32] = mca[i];
      mp_bus[i*32 +: 32] = mpa[i];
    end
  endtask

  // One full transaction; entered at a negedge while the DUT is idle.
  task automatic txn(input bit drop, output int kk);
    int          cyc;
    int          starts;
    bit          seen;
    logic [63:0] exp_p;
    kk = model_pick(req_i, rr);
    drive_ops();
    exp_p = 64'(mca[kk]) * 64'(mpa[kk]);
    cyc = 0;
    while (!busy_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("grant_seen", 64'(busy_o), 64'd1);
    check("gnt", 64'(gnt_o), 64'(4'b0001 << kk));
    check("start_issue", 64'(mul_start_o), 64'd1);
    check("mc", 64'(mul_mc_o), 64'(mca[kk]));
    check("mp", 64'(mul_mp_o), 64'(mpa[kk]));
    starts = 1;
    seen   = 1'b0;
    cyc    = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_o != 4'b0) seen = 1'b1;
      else if (mul_start_o) starts++;
    end
    check("rsp_seen", 64'(seen), 64'd1);
    check("rsp_valid", 64'(rsp_valid_o), 64'(4'b0001 << kk));
    check("rsp_p", rsp_p_o, exp_p);
    check("rsp_err", 64'(rsp_err_o), 64'd0);
    check("start_once", 64'(starts), 64'd1);
    check("gnt_resp", 64'(gnt_o), 64'(4'b0001 << kk));
    if (drop) req_i[kk] = 1'b0;
    rr = (kk + 1) % 4;
    mca[kk] = $urandom;
    mpa[kk] = $urandom;
    drive_ops();
    @(negedge clk);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_gnt", 64'(gnt_o), 64'd0);
    check("idle_valid", 64'(rsp_valid_o), 64'd0);
    check("p_hold", rsp_p_o, exp_p);
  endtask

  initial begin
    rst       = 1'b1;
    req_i     = '0;
    stub_hold = 1'b0;
    late_done = 1'b0;
    rr        = 0;
    for (int i = 0; i < 4; i++) begin
      mca[i] = $urandom;
      mpa[i] = $urandom;
    end
    drive_ops();
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_p", rsp_p_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_start", 64'(mul_start_o), 64'd0);
    check("rst_mc", 64'(mul_mc_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 2, then prove the pointer moved to 3.
    mca[2] = 32'd3;
    mpa[2] = 32'd5;
    req_i  = 4'b0100;
    txn(1'b1, k);
    check("single_k", 64'(k), 64'd2);
    check("single_rr", 64'(rr), 64'd3);
    req_i = 4'b1100;
    txn(1'b1, k);
    check("rr_from_3", 64'(k), 64'd3);
    req_i = '0;
    @(negedge clk);

    // Contention: 1011 held, each drops on its own response.
    req_i = 4'b1011;
    for (int t = 0; t < 3; t++) txn(1'b1, k);
    check("cont_last", 64'(k), 64'd3);
    repeat (3) begin
      @(negedge clk);
      check("cont_idle", 64'(busy_o), 64'd0);
    end

    // Fairness: two requesters never dropping alternate.
    req_i = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      txn(1'b0, k);
      check("fair_order", 64'(k), 64'(t % 2));
    end
    req_i = '0;
    @(negedge clk);
    @(negedge clk);

    // Edge operands.
    mca[1] = 32'hFFFF_FFFF;
    mpa[1] = 32'hFFFF_FFFF;
    req_i  = 4'b0010;
    txn(1'b1, k);
    check("max_prod", rsp_p_o, 64'hFFFF_FFFE_0000_0001);
    mca[3] = 32'd0;
    mpa[3] = $urandom;
    req_i  = 4'b1000;
    txn(1'b1, k);
    check("zero_prod", rsp_p_o, 64'd0);

    // Randomized traffic.
    for (int t = 0; t < 12; t++) begin
      req_i = req_i | 4'($urandom_range(0, 15));
      if (req_i == 4'b0) req_i[$urandom_range(0, 3)] = 1'b1;
      txn(1'($urandom_range(0, 1)), k);
    end
    req_i = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in WAIT discards the in-flight result.
    mca[0] = 32'd7;
    mpa[0] = 32'd9;
    drive_ops();
    stub_hold = 1'b1;
    req_i = 4'b0110;
    n = 0;
    while (!busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("wait_start_low", 64'(mul_start_o), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", 64'(gnt_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_valid", 64'(rsp_valid_o), 64'd0);
    check("arst_p", rsp_p_o, 64'd0);
    check("arst_mc", 64'(mul_mc_o), 64'd0);
    check("arst_mp", 64'(mul_mp_o), 64'd0);
    check("arst_err", 64'(rsp_err_o), 64'd0);
    @(negedge clk);
    check("arst_hold_valid", 64'(rsp_valid_o), 64'd0);
    rst       = 1'b0;
    stub_hold = 1'b0;
    rr        = 0;
    txn(1'b1, k);
    check("post_rst_k", 64'(k), 64'd1);
    req_i = '0;
    @(negedge clk);

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog: done never arrives, response after 8 WAIT cycles with error.
    stub_hold = 1'b1;
    req_i = 4'b0001;
    drive_ops();
    n = 0;
    while (!busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (rsp_valid_o == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_wait_cycles", 64'(n - 1), 64'd8);
    check("to_valid", 64'(rsp_valid_o), 64'b0001);
    check("to_err", 64'(rsp_err_o), 64'd1);
    check("to_p", rsp_p_o, 64'd0);
    req_i = '0;
    rr = 1;
    @(negedge clk);
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    check("late_done_busy", 64'(busy_o), 64'd0);
    check("late_done_valid", 64'(rsp_valid_o), 64'd0);
    stub_hold = 1'b0;
    req_i = 4'b0100;
    txn(1'b1, k);
    req_i = '0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
